// File: rtl/instr_fetch_unit.sv
// MIPS32 instruction-fetch stage: owns the PC, drives combinational imem, fills IF/ID.
// Latency: one edge from PC to IF/ID; redirect costs one bubble; stall freezes PC and IF/ID.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] PROG_BYTES = 32'h0000_000C
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_stall,
    input  logic        i_branch_taken,
    input  logic [31:0] i_branch_target,
    input  logic        i_jump,
    input  logic [25:0] i_jump_target,
    output logic [31:0] o_address,
    input  logic [31:0] i_instruction,
    output logic [31:0] o_if_id_instr,
    output logic [31:0] o_if_id_pc_plus4,
    output logic        o_if_id_valid,
    output logic        o_fault,
    output logic [31:0] o_fetch_count
);

    typedef enum logic {
        S_RUN  = 1'b0,
        S_HALT = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic [31:0] r_pc;
    logic [31:0] r_instr;
    logic [31:0] r_pc4;
    logic        r_valid;
    logic        r_fault;
    logic [31:0] r_count;

    logic [31:0] w_pc_nxt;
    logic [31:0] w_instr_nxt;
    logic [31:0] w_pc4_nxt;
    logic        w_valid_nxt;
    logic        w_fault_nxt;
    logic [31:0] w_count_nxt;

    logic [31:0] w_pc_plus4;
    logic [31:0] w_jump_pc;
    logic        w_bad_pc;

    assign w_pc_plus4 = r_pc + 32'd4;
    // J keeps the region bits of the instruction in ID, i.e. the one now in IF/ID.
    assign w_jump_pc  = {r_pc4[31:28], i_jump_target, 2'b00};
    assign w_bad_pc   = (r_pc[1:0] != 2'b00) || (r_pc >= PROG_BYTES);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_RUN;
            r_pc    <= RESET_PC;
            r_instr <= 32'h0000_0000;
            r_pc4   <= 32'h0000_0000;
            r_valid <= 1'b0;
            r_fault <= 1'b0;
            r_count <= 32'h0000_0000;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_instr <= w_instr_nxt;
            r_pc4   <= w_pc4_nxt;
            r_valid <= w_valid_nxt;
            r_fault <= w_fault_nxt;
            r_count <= w_count_nxt;
        end
    end

    // Redirects outrank the fault check so a bad PC on a squashed path never halts.
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_instr_nxt = r_instr;
        w_pc4_nxt   = r_pc4;
        w_valid_nxt = r_valid;
        w_fault_nxt = r_fault;
        w_count_nxt = r_count;

        case (r_state)
            S_RUN: begin
                if (i_branch_taken) begin
                    w_pc_nxt    = i_branch_target;
                    w_valid_nxt = 1'b0;
                end else if (i_jump) begin
                    w_pc_nxt    = w_jump_pc;
                    w_valid_nxt = 1'b0;
                end else if (w_bad_pc) begin
                    w_state_nxt = S_HALT;
                    w_fault_nxt = 1'b1;
                    w_valid_nxt = 1'b0;
                end else if (!i_stall) begin
                    w_instr_nxt = i_instruction;
                    w_pc4_nxt   = w_pc_plus4;
                    w_valid_nxt = 1'b1;
                    w_pc_nxt    = w_pc_plus4;
                    w_count_nxt = r_count + 32'd1;
                end
            end
            S_HALT: begin
                w_valid_nxt = 1'b0;
            end
            default: begin
                w_state_nxt = S_HALT;
                w_fault_nxt = 1'b1;
                w_valid_nxt = 1'b0;
            end
        endcase
    end

    assign o_address        = r_pc;
    assign o_if_id_instr    = r_instr;
    assign o_if_id_pc_plus4 = r_pc4;
    assign o_if_id_valid    = r_valid;
    assign o_fault          = r_fault;
    assign o_fetch_count    = r_count;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: driver queues expected post-edge state, monitor checks it.
module tb_instr_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        br;
    logic [31:0] br_tgt;
    logic        jmp;
    logic [25:0] jmp_tgt;
    logic [31:0] addr;
    logic [31:0] instr;
    logic [31:0] ifid_instr;
    logic [31:0] ifid_pc4;
    logic        ifid_valid;
    logic        fault;
    logic [31:0] fcount;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        string       tag;
        logic [31:0] addr;
        logic [31:0] instr;
        logic [31:0] pc4;
        logic        valid;
        logic        fault;
        logic [31:0] cnt;
    } exp_t;

    exp_t exp_q[$];

    instr_fetch_unit #(
        .RESET_PC   (32'h0000_0000),
        .PROG_BYTES (32'h0000_000C)
    ) dut (
        .i_clk            (clk),
        .i_rst_n          (rst_n),
        .i_stall          (stall),
        .i_branch_taken   (br),
        .i_branch_target  (br_tgt),
        .i_jump           (jmp),
        .i_jump_target    (jmp_tgt),
        .o_address        (addr),
        .i_instruction    (instr),
        .o_if_id_instr    (ifid_instr),
        .o_if_id_pc_plus4 (ifid_pc4),
        .o_if_id_valid    (ifid_valid),
        .o_fault          (fault),
        .o_fetch_count    (fcount)
    );

    // Combinational program memory
    always_comb begin
        case (addr)
            32'h0000_0000: instr = 32'h2008_0002;
            32'h0000_0004: instr = 32'h2109_0004;
            32'h0000_0008: instr = 32'h0109_5020;
            default:       instr = 32'h0000_0000;
        endcase
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: time limit reached, compared=%0d", n_cmp);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, req);
        end
    endtask

    task automatic chk_all(input exp_t e);
        chk({e.tag, ".addr"},  addr,               e.addr);
        chk({e.tag, ".instr"}, ifid_instr,         e.instr);
        chk({e.tag, ".pc4"},   ifid_pc4,           e.pc4);
        chk({e.tag, ".valid"}, {31'h0, ifid_valid}, {31'h0, e.valid});
        chk({e.tag, ".fault"}, {31'h0, fault},      {31'h0, e.fault});
        chk({e.tag, ".count"}, fcount,             e.cnt);
    endtask

    // Monitor: one expectation per rising edge, sampled just after the edge
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk_all(e);
            end
        end
    end

    // Called in the low phase: drives inputs for the next edge and queues the state after it.
    task automatic step(input string tag, input logic b, input logic [31:0] bt,
                        input logic j, input logic [25:0] jt, input logic s,
                        input logic [31:0] e_addr, input logic [31:0] e_instr,
                        input logic [31:0] e_pc4, input logic e_valid,
                        input logic e_fault, input logic [31:0] e_cnt);
        exp_t e;
        br      = b;
        br_tgt  = bt;
        jmp     = j;
        jmp_tgt = jt;
        stall   = s;
        e.tag   = tag;
        e.addr  = e_addr;
        e.instr = e_instr;
        e.pc4   = e_pc4;
        e.valid = e_valid;
        e.fault = e_fault;
        e.cnt   = e_cnt;
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, ".addr"},  addr,               32'h0);
        chk({tag, ".instr"}, ifid_instr,         32'h0);
        chk({tag, ".pc4"},   ifid_pc4,           32'h0);
        chk({tag, ".valid"}, {31'h0, ifid_valid}, 32'h0);
        chk({tag, ".fault"}, {31'h0, fault},      32'h0);
        chk({tag, ".count"}, fcount,             32'h0);
    endtask

    // Asynchronous reset pulse in the low phase; state must clear before any edge.
    task automatic async_reset(input string tag);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_state(tag);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n   = 1'b0;
        stall   = 1'b0;
        br      = 1'b0;
        br_tgt  = 32'h0;
        jmp     = 1'b0;
        jmp_tgt = 26'h0;
        #3;
        check_reset_state("reset");
        @(negedge clk);
        #2;
        rst_n = 1'b1;

        // Sequential run into the end of the program region
        step("seq1",  0, 32'h0, 0, 26'h0, 0, 32'h4, 32'h2008_0002, 32'h4, 1, 0, 32'd1);
        step("seq2",  0, 32'h0, 0, 26'h0, 0, 32'h8, 32'h2109_0004, 32'h8, 1, 0, 32'd2);
        step("seq3",  0, 32'h0, 0, 26'h0, 0, 32'hC, 32'h0109_5020, 32'hC, 1, 0, 32'd3);
        step("seqf",  0, 32'h0, 0, 26'h0, 0, 32'hC, 32'h0109_5020, 32'hC, 0, 1, 32'd3);
        step("halt1", 0, 32'h0, 0, 26'h0, 0, 32'hC, 32'h0109_5020, 32'hC, 0, 1, 32'd3);
        drain();
        async_reset("rst1");

        // Stall for two cycles after the first fetch
        step("st_f1", 0, 32'h0, 0, 26'h0, 0, 32'h4, 32'h2008_0002, 32'h4, 1, 0, 32'd1);
        step("st_h1", 0, 32'h0, 0, 26'h0, 1, 32'h4, 32'h2008_0002, 32'h4, 1, 0, 32'd1);
        step("st_h2", 0, 32'h0, 0, 26'h0, 1, 32'h4, 32'h2008_0002, 32'h4, 1, 0, 32'd1);
        step("st_go", 0, 32'h0, 0, 26'h0, 0, 32'h8, 32'h2109_0004, 32'h8, 1, 0, 32'd2);

        // Branch wins over simultaneous stall and jump
        step("br_rd", 1, 32'h0, 1, 26'h3, 1, 32'h0, 32'h2109_0004, 32'h8, 0, 0, 32'd2);
        step("br_tg", 0, 32'h0, 0, 26'h0, 0, 32'h4, 32'h2008_0002, 32'h4, 1, 0, 32'd3);

        // Jump with IF_ID_PCPlus4=4
        step("jp_rd", 0, 32'h0, 1, 26'h2, 0, 32'h8, 32'h2008_0002, 32'h4, 0, 0, 32'd3);
        step("jp_tg", 0, 32'h0, 0, 26'h0, 0, 32'hC, 32'h0109_5020, 32'hC, 1, 0, 32'd4);

        // PC is now out of range but the redirect outranks the fault; target 6 faults next edge
        step("mis_rd", 1, 32'h6, 0, 26'h0, 0, 32'h6, 32'h0109_5020, 32'hC, 0, 0, 32'd4);
        step("mis_f",  0, 32'h0, 0, 26'h0, 0, 32'h6, 32'h0109_5020, 32'hC, 0, 1, 32'd4);
        step("mis_h1", 1, 32'h0, 0, 26'h0, 0, 32'h6, 32'h0109_5020, 32'hC, 0, 1, 32'd4);
        step("mis_h2", 0, 32'h0, 1, 26'h1, 1, 32'h6, 32'h0109_5020, 32'hC, 0, 1, 32'd4);
        drain();
        async_reset("rst2");

        step("re_f1", 0, 32'h0, 0, 26'h0, 0, 32'h4, 32'h2008_0002, 32'h4, 1, 0, 32'd1);
        step("re_f2", 0, 32'h0, 0, 26'h0, 1, 32'h4, 32'h2008_0002, 32'h4, 1, 0, 32'd1);
        drain();
        // Reset while stalled clears immediately too
        async_reset("rst3");
        stall = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
